// File: rtl/vc_flit_fifo_if.sv
// Handshake/data bundle for vc_flit_fifo: write port, read port, per-VC status flags.
// With VC_FIFO_ERR_EN defined, the sticky error flags and their clear input are carried too.
interface vc_flit_fifo_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int VC_NUM       = 4,
  parameter int VC_SEL_WIDTH = 2
);
  logic                    wr_en;
  logic [VC_SEL_WIDTH-1:0] wr_vc;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [VC_SEL_WIDTH-1:0] rd_vc;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [VC_SEL_WIDTH-1:0] rd_vc_out;
  logic [VC_NUM-1:0]       vc_not_empty;
  logic [VC_NUM-1:0]       vc_full;
  logic [VC_NUM-1:0]       vc_almost_full;
`ifdef VC_FIFO_ERR_EN
  logic                    err_clr;
  logic [VC_NUM-1:0]       err_overflow;
  logic [VC_NUM-1:0]       err_underflow;

  modport master (
    output wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
    input  rd_data, rd_valid, rd_vc_out, vc_not_empty, vc_full, vc_almost_full,
           err_overflow, err_underflow
  );
  modport slave (
    input  wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
    output rd_data, rd_valid, rd_vc_out, vc_not_empty, vc_full, vc_almost_full,
           err_overflow, err_underflow
  );
`else
  modport master (
    output wr_en, wr_vc, wr_data, rd_en, rd_vc,
    input  rd_data, rd_valid, rd_vc_out, vc_not_empty, vc_full, vc_almost_full
  );
  modport slave (
    input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
    output rd_data, rd_valid, rd_vc_out, vc_not_empty, vc_full, vc_almost_full
  );
`endif
endinterface

// File: rtl/vc_flit_fifo.sv
// Virtual-channel flit FIFO: VC_NUM independent queues in one RAM addressed {vc, ptr}.
// Define VC_FIFO_ERR_EN to add sticky per-VC overflow/underflow flags cleared by err_clr.
module vc_flit_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int VC_NUM        = 4,
  parameter int VC_SEL_WIDTH  = 2,
  parameter int VC_ADDR_WIDTH = 3,
  parameter int AFULL_MARGIN  = 2
) (
  input logic         clk,
  input logic         rst_n,
  vc_flit_fifo_if.slave bus
);
  localparam int DEPTH  = 2 ** VC_ADDR_WIDTH;
  localparam int CNT_W  = VC_ADDR_WIDTH + 1;
  localparam int RAM_AW = VC_SEL_WIDTH + VC_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0]    r_mem [VC_NUM*DEPTH];
  logic [VC_ADDR_WIDTH-1:0] r_wr_ptr [VC_NUM];
  logic [VC_ADDR_WIDTH-1:0] r_rd_ptr [VC_NUM];
  logic [CNT_W-1:0]         r_count  [VC_NUM];
  logic [DATA_WIDTH-1:0]    r_rd_data;
  logic                     r_rd_valid;
  logic [VC_SEL_WIDTH-1:0]  r_rd_vc_out;

  logic [VC_NUM-1:0] w_not_empty;
  logic [VC_NUM-1:0] w_full;
  logic [VC_NUM-1:0] w_afull;
  logic [VC_NUM-1:0] w_inc;
  logic [VC_NUM-1:0] w_dec;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [RAM_AW-1:0] w_wr_addr;
  logic [RAM_AW-1:0] w_rd_addr;

  always_comb begin
    w_not_empty = '0;
    w_full      = '0;
    w_afull     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_not_empty[v] = (r_count[v] != '0);
      w_full[v]      = (r_count[v] == CNT_FULL);
      w_afull[v]     = (r_count[v] >= CNT_AFULL);
    end
  end

  // Acceptance looks only at registered state: no same-cycle write-to-read bypass.
  assign w_wr_acc  = bus.wr_en && !w_full[bus.wr_vc];
  assign w_rd_acc  = bus.rd_en && w_not_empty[bus.rd_vc];
  assign w_wr_addr = {bus.wr_vc, r_wr_ptr[bus.wr_vc]};
  assign w_rd_addr = {bus.rd_vc, r_rd_ptr[bus.rd_vc]};

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_wr_acc) w_inc[bus.wr_vc] = 1'b1;
    if (w_rd_acc) w_dec[bus.rd_vc] = 1'b1;
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_inc[v]) r_wr_ptr[v] <= r_wr_ptr[v] + 1'b1;
        if (w_dec[v]) r_rd_ptr[v] <= r_rd_ptr[v] + 1'b1;
        if (w_inc[v] && !w_dec[v])
          r_count[v] <= r_count[v] + 1'b1;
        else if (w_dec[v] && !w_inc[v])
          r_count[v] <= r_count[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_vc_out <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data   <= r_mem[w_rd_addr];
        r_rd_vc_out <= bus.rd_vc;
      end
    end
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_vc_out      = r_rd_vc_out;
  assign bus.vc_not_empty   = w_not_empty;
  assign bus.vc_full        = w_full;
  assign bus.vc_almost_full = w_afull;

`ifdef VC_FIFO_ERR_EN
  logic [VC_NUM-1:0] r_err_ovf;
  logic [VC_NUM-1:0] r_err_unf;
  logic [VC_NUM-1:0] w_ovf_evt;
  logic [VC_NUM-1:0] w_unf_evt;

  always_comb begin
    w_ovf_evt = '0;
    w_unf_evt = '0;
    if (bus.wr_en && w_full[bus.wr_vc])       w_ovf_evt[bus.wr_vc] = 1'b1;
    if (bus.rd_en && !w_not_empty[bus.rd_vc]) w_unf_evt[bus.rd_vc] = 1'b1;
  end

  // A new event in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= '0;
      r_err_unf <= '0;
    end else begin
      r_err_ovf <= (bus.err_clr ? '0 : r_err_ovf) | w_ovf_evt;
      r_err_unf <= (bus.err_clr ? '0 : r_err_unf) | w_unf_evt;
    end
  end

  assign bus.err_overflow  = r_err_ovf;
  assign bus.err_underflow = r_err_unf;
`else
`endif
endmodule
